// File: rtl/y86_prog_loader_pkg.sv
// Shared constants and the loader state encoding for the y86 program loader.
package y86_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_e;

endpackage

// File: rtl/y86_prog_loader.sv
// Receives a framed byte stream (SYNC, LEN_HI, LEN_LO, payload, XOR checksum), writes the
// payload into imem from address 0, and holds the CPU until a frame loads with a good checksum.
import y86_prog_loader_pkg::*;

module y86_prog_loader #(
    parameter int IMEM_BYTES = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       byte_count,
    output logic [2:0]        dbg_state
);

    localparam logic [15:0] LEN_MAX = 16'(IMEM_BYTES);

    // Handshake: a byte moves only on a posedge where rx_valid and rx_ready are both high;
    // rx_valid low is a gap and changes nothing.
    ld_state_e         state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              xfer;
    logic [15:0]       len_new;

    assign rx_ready   = !rst && (state_q != ST_DONE);
    assign xfer       = rx_valid && rx_ready;
    assign len_new    = {len_q[15:8], rx_data};

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERR);
    assign byte_count = count_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                // A sync byte restarts cleanly, also after a rejected frame.
                if (xfer && rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN_H;
                    count_d = '0;
                    csum_d  = '0;
                    waddr_d = '0;
                end
            end
            ST_LEN_H: begin
                if (xfer) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (xfer) begin
                    len_d = len_new;
                    if (len_new == 16'd0 || len_new > LEN_MAX) state_d = ST_ERR;
                    else                                       state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    // The byte count doubles as the write address; len <= IMEM_BYTES keeps it in range.
                    we_d    = 1'b1;
                    waddr_d = count_q[ADDR_W-1:0];
                    wdata_d = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    count_d = count_q + 16'd1;
                    if (count_q + 16'd1 == len_q) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (xfer) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_y86_prog_loader.sv
// Directed bench for y86_prog_loader: per-cycle vector table plus hand sequences for gaps,
// mid-frame reset and back-to-back throughput.
module tb_y86_prog_loader;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [9:0]  addr;
        logic [7:0]  wd;
        logic        hold;
        logic        done;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [7:0]  imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] byte_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    y86_prog_loader #(.IMEM_BYTES(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_count (byte_count),
        .dbg_state  (dbg_state)
    );

    // write log: what an imem would see on each strobe, plus the cycle it happened in
    int          cyc = 0;
    int          log_n = 0;
    logic [9:0]  log_addr [0:255];
    logic [7:0]  log_data [0:255];
    int          log_cyc  [0:255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we && log_n < 256) begin
            log_addr[log_n] <= imem_addr;
            log_data[log_n] <= imem_wdata;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
        end
    end

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q [$];
    vec_t        tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [9:0] addr,
                                input logic [7:0] wd, input logic hold, input logic done,
                                input logic err, input logic [15:0] cnt);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.addr = addr; t.wd = wd;
        t.hold = hold; t.done = done; t.err = err; t.cnt = cnt;
        return t;
    endfunction

    // driver tasks
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        step(N, Y, d);
        for (int g = 0; g < gap; g++) step(N, N, 8'h00);
    endtask

    task automatic check_log(input string name, input int start);
        chk({name, "_nwr"}, 32'(log_n - start), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && start + k < log_n; k++)
            chk({name, "_wr"}, {14'd0, log_addr[start + k], log_data[start + k]}, {14'd0, exp_q[k]});
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name, input logic rdy, input logic hold,
                                      input logic done, input logic err, input logic [15:0] cnt);
        chk({name, "_rdy"},  32'(rx_ready),   32'(rdy));
        chk({name, "_hold"}, 32'(cpu_hold),   32'(hold));
        chk({name, "_done"}, 32'(load_done),  32'(done));
        chk({name, "_err"},  32'(load_err),   32'(err));
        chk({name, "_cnt"},  32'(byte_count), 32'(cnt));
    endtask

    initial begin
        int          s;
        logic [7:0]  d;
        logic [7:0]  cs;

        // reset, then clean load: 30^F2^01 = C3
        tbl.push_back(mk(Y, N, 8'h00, N, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'hA5, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h00, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h03, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h30, Y, Y, 10'd0, 8'h30, Y, N, N, 16'd1));
        tbl.push_back(mk(N, Y, 8'hF2, Y, Y, 10'd1, 8'hF2, Y, N, N, 16'd2));
        tbl.push_back(mk(N, Y, 8'h01, Y, Y, 10'd2, 8'h01, Y, N, N, 16'd3));
        tbl.push_back(mk(N, Y, 8'hC3, N, N, 10'd0, 8'h00, N, Y, N, 16'd3));
        tbl.push_back(mk(N, N, 8'h00, N, N, 10'd0, 8'h00, N, Y, N, 16'd3));
        tbl.push_back(mk(N, Y, 8'hA5, N, N, 10'd0, 8'h00, N, Y, N, 16'd3));
        // bad checksum (10^20 = 30, sent 31), then a clean 1-byte frame
        tbl.push_back(mk(Y, N, 8'h00, N, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'hA5, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h00, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h02, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h10, Y, Y, 10'd0, 8'h10, Y, N, N, 16'd1));
        tbl.push_back(mk(N, Y, 8'h20, Y, Y, 10'd1, 8'h20, Y, N, N, 16'd2));
        tbl.push_back(mk(N, Y, 8'h31, Y, N, 10'd0, 8'h00, Y, N, Y, 16'd2));
        tbl.push_back(mk(N, Y, 8'hA5, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h00, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h01, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h7E, Y, Y, 10'd0, 8'h7E, Y, N, N, 16'd1));
        tbl.push_back(mk(N, Y, 8'h7E, N, N, 10'd0, 8'h00, N, Y, N, 16'd1));
        // length rejects: 0x0401 = 1025, then 0; ERR ignores non-sync bytes
        tbl.push_back(mk(Y, N, 8'h00, N, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'hA5, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h04, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h01, Y, N, 10'd0, 8'h00, Y, N, Y, 16'd0));
        tbl.push_back(mk(N, Y, 8'hA5, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h00, Y, N, 10'd0, 8'h00, Y, N, N, 16'd0));
        tbl.push_back(mk(N, Y, 8'h00, Y, N, 10'd0, 8'h00, Y, N, Y, 16'd0));
        tbl.push_back(mk(N, Y, 8'h55, Y, N, 10'd0, 8'h00, Y, N, Y, 16'd0));

        step(Y, N, 8'h00);
        s = log_n;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            chk($sformatf("v%0d_rdy", i),  32'(rx_ready),   32'(tbl[i].rdy));
            chk($sformatf("v%0d_we", i),   32'(imem_we),    32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_addr", i), 32'(imem_addr),  32'(tbl[i].addr));
                chk($sformatf("v%0d_wd", i),   32'(imem_wdata), 32'(tbl[i].wd));
            end
            chk($sformatf("v%0d_hold", i), 32'(cpu_hold),   32'(tbl[i].hold));
            chk($sformatf("v%0d_done", i), 32'(load_done),  32'(tbl[i].done));
            chk($sformatf("v%0d_err", i),  32'(load_err),   32'(tbl[i].err));
            chk($sformatf("v%0d_cnt", i),  32'(byte_count), 32'(tbl[i].cnt));
        end
        exp_q = '{{10'd0, 8'h30}, {10'd1, 8'hF2}, {10'd2, 8'h01},
                  {10'd0, 8'h10}, {10'd1, 8'h20}, {10'd0, 8'h7E}};
        check_log("table", s);

        // gaps and leading garbage
        step(Y, N, 8'h00);
        s = log_n;
        send(8'h00, 0);
        send(8'hFF, 0);
        chk("garbage_state", 32'(dbg_state), 32'(0));
        send(8'hA5, 1);
        send(8'h00, 2);
        send(8'h03, 2);
        send(8'h30, 2);
        send(8'hF2, 2);
        send(8'h01, 2);
        send(8'hC3, 0);
        check_idle_outputs("gaps", N, N, Y, N, 16'd3);
        exp_q = '{{10'd0, 8'h30}, {10'd1, 8'hF2}, {10'd2, 8'h01}};
        check_log("gaps", s);

        // reset after 2 of 5 payload bytes
        step(Y, N, 8'h00);
        s = log_n;
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h05, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        step(Y, N, 8'h00);
        check_idle_outputs("midrst", N, Y, N, N, 16'd0);
        chk("midrst_we",    32'(imem_we),    32'(0));
        chk("midrst_addr",  32'(imem_addr),  32'(0));
        chk("midrst_wdata", 32'(imem_wdata), 32'(0));
        step(N, N, 8'h00);
        check_idle_outputs("midrst_after", Y, Y, N, N, 16'd0);
        step(N, Y, 8'h33);
        step(N, N, 8'h00);
        exp_q = '{{10'd0, 8'h11}, {10'd1, 8'h22}};
        check_log("midrst", s);
        s = log_n;
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h44, 0);
        send(8'h44, 0);
        check_idle_outputs("reload", N, N, Y, N, 16'd1);
        step(N, N, 8'h00);
        exp_q = '{{10'd0, 8'h44}};
        check_log("reload", s);

        // 16-byte back-to-back frame
        step(Y, N, 8'h00);
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h10, 0);
        s = log_n;
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 17 + 3);
            cs = cs ^ d;
            step(N, Y, d);
            chk($sformatf("tp%0d_we", i),   32'(imem_we),    32'(1));
            chk($sformatf("tp%0d_addr", i), 32'(imem_addr),  32'(i));
            chk($sformatf("tp%0d_wd", i),   32'(imem_wdata), 32'(d));
            exp_q.push_back({10'(i), d});
        end
        step(N, Y, cs);
        chk("tp_we_end", 32'(imem_we), 32'(0));
        check_idle_outputs("tp", N, N, Y, N, 16'd16);
        check_log("tp", s);
        for (int k = 0; k < 15 && s + k + 1 < log_n; k++)
            chk($sformatf("tp_consec%0d", k), 32'(log_cyc[s + k + 1]), 32'(log_cyc[s + k] + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
